// File: rtl/bti_pkg.sv
// Shared BTI definitions: tid width, host-index type and the index-width helper.
package bti_pkg;

    localparam int BTI_TIDW = 4;

    // Host index type wide enough for any practical host count.
    typedef logic [7:0] bti_hst_idx_t;

    // Index width for n hosts, never below one bit so a single-host build still has a port.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bti_arb_rr_pick.sv
// Combinational round-robin picker: lowest requester at or above ptr, else lowest overall.
module rr_pick
    import bti_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [N-1:0] masked;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        masked = '0;
        for (int i = 0; i < N; i++) begin
            masked[i] = req[i] & (i >= int'(ptr));
        end
    end

    // Descending scans with last-write-wins leave the lowest index; the masked pass overrides.
    always_comb begin
        gnt_idx = '0;
        any     = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) gnt_idx = IW'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (masked[i]) gnt_idx = IW'(i);
        end
    end

endmodule

// File: rtl/bti_arb.sv
// N:1 BTI arbiter with one outstanding transaction; responses steer back to the issuing host.
// Req pkt = {we, tid, addr, data}; rsp pkt = {ok, tid, data}; both pass through untouched.
module bti_arb
    import bti_pkg::*;
#(
    parameter int BTI_AW  = 32,
    parameter int BTI_DW  = 32,
    parameter int HST_NUM = 2
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [HST_NUM-1:0]                          host_bti_req_slvs_vld,
    output logic [HST_NUM-1:0]                          host_bti_req_slvs_rdy,
    input  logic [HST_NUM-1:0][BTI_AW+BTI_DW+BTI_TIDW:0] host_bti_req_slvs_pkt,
    output logic [HST_NUM-1:0]                          host_bti_rsp_msts_vld,
    input  logic [HST_NUM-1:0]                          host_bti_rsp_msts_rdy,
    output logic [HST_NUM-1:0][BTI_DW+BTI_TIDW:0]       host_bti_rsp_msts_pkt,
    output logic                                        gst_bti_req_mst_vld,
    input  logic                                        gst_bti_req_mst_rdy,
    output logic [BTI_AW+BTI_DW+BTI_TIDW:0]             gst_bti_req_mst_pkt,
    input  logic                                        gst_bti_rsp_slv_vld,
    output logic                                        gst_bti_rsp_slv_rdy,
    input  logic [BTI_DW+BTI_TIDW:0]                    gst_bti_rsp_slv_pkt,
    output logic                                        stray_rsp
);

    localparam int IDXW = clog2_min1(HST_NUM);

    logic [IDXW-1:0] rr_ptr, lock_idx, pend_idx, pick_idx, grant;
    logic            lock_vld, pend, pick_any;
    logic            pend_rdy, rsp_hsk, can_issue, req_hsk;

    rr_pick #(.N(HST_NUM), .IW(IDXW)) u_pick (
        .req     (host_bti_req_slvs_vld),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Handshake outputs are gated by rst_n so the ports read idle the instant reset asserts.
    always_comb begin
        grant               = lock_vld ? lock_idx : pick_idx;
        pend_rdy            = 1'b0;
        gst_bti_req_mst_pkt = '0;
        for (int i = 0; i < HST_NUM; i++) begin
            if (pend_idx == IDXW'(i)) pend_rdy = host_bti_rsp_msts_rdy[i];
            if (grant == IDXW'(i)) gst_bti_req_mst_pkt = host_bti_req_slvs_pkt[i];
        end
        gst_bti_rsp_slv_rdy = rst_n & (pend ? pend_rdy : 1'b1);
        rsp_hsk             = gst_bti_rsp_slv_vld & gst_bti_rsp_slv_rdy;
        can_issue           = ~pend | rsp_hsk;
        gst_bti_req_mst_vld = rst_n & (lock_vld | pick_any) & can_issue;
        req_hsk             = gst_bti_req_mst_vld & gst_bti_req_mst_rdy;
        for (int i = 0; i < HST_NUM; i++) begin
            host_bti_req_slvs_rdy[i] = rst_n & (grant == IDXW'(i)) & gst_bti_req_mst_rdy & can_issue;
            host_bti_rsp_msts_vld[i] = gst_bti_rsp_slv_vld & pend & (pend_idx == IDXW'(i));
            host_bti_rsp_msts_pkt[i] = gst_bti_rsp_slv_pkt;
        end
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            lock_vld  <= 1'b0;
            lock_idx  <= '0;
            pend      <= 1'b0;
            pend_idx  <= '0;
            stray_rsp <= 1'b0;
        end else begin
            stray_rsp <= gst_bti_rsp_slv_vld & ~pend;
            if (req_hsk) begin
                pend     <= 1'b1;
                pend_idx <= grant;
                rr_ptr   <= (grant == IDXW'(HST_NUM - 1)) ? '0 : grant + 1'b1;
                lock_vld <= 1'b0;
            end else begin
                if (rsp_hsk) pend <= 1'b0;
                // Offered but not taken: freeze the grant so the pkt holds until accepted.
                if (gst_bti_req_mst_vld) begin
                    lock_vld <= 1'b1;
                    lock_idx <= grant;
                end
            end
        end
    end

endmodule

// File: tb/tb_bti_arb.sv
// Directed bench for bti_arb with two hosts: single read, alternation, lock, overlap, backpressure, stray, reset.
module tb_bti_arb;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        hv, hrdy, hrsp_vld, hrsp_rdy;
    logic [1:0][68:0]  hpkt;
    logic [1:0][36:0]  hrsp_pkt;
    logic              g_req_vld, g_req_rdy, g_rsp_vld, g_rsp_rdy, stray;
    logic [68:0]       g_req_pkt, p0, p1;
    logic [36:0]       g_rsp_pkt, r;
    int                n_pass = 0;
    int                n_total = 0;
    int                last_g;

    always #5 clk = ~clk;

    bti_arb #(.BTI_AW(32), .BTI_DW(32), .HST_NUM(2)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .host_bti_req_slvs_vld (hv),
        .host_bti_req_slvs_rdy (hrdy),
        .host_bti_req_slvs_pkt (hpkt),
        .host_bti_rsp_msts_vld (hrsp_vld),
        .host_bti_rsp_msts_rdy (hrsp_rdy),
        .host_bti_rsp_msts_pkt (hrsp_pkt),
        .gst_bti_req_mst_vld   (g_req_vld),
        .gst_bti_req_mst_rdy   (g_req_rdy),
        .gst_bti_req_mst_pkt   (g_req_pkt),
        .gst_bti_rsp_slv_vld   (g_rsp_vld),
        .gst_bti_rsp_slv_rdy   (g_rsp_rdy),
        .gst_bti_rsp_slv_pkt   (g_rsp_pkt),
        .stray_rsp             (stray)
    );

    function automatic logic [68:0] mk_req(input logic we, input logic [3:0] tid,
                                           input logic [31:0] addr, input logic [31:0] data);
        return {we, tid, addr, data};
    endfunction

    function automatic logic [36:0] mk_rsp(input logic ok, input logic [3:0] tid, input logic [31:0] data);
        return {ok, tid, data};
    endfunction

    function automatic logic [1:0] oh(input int g);
        return 2'b01 << g;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; hv = 2'b11; hpkt = '0; hrsp_rdy = 2'b11;
        g_req_rdy = 1'b1; g_rsp_vld = 1'b1; g_rsp_pkt = '0;
        tick(); #1;
        check("rst_req_vld", g_req_vld, 0);
        check("rst_hrdy", hrdy, 0);
        check("rst_hrsp_vld", hrsp_vld, 0);
        check("rst_rsp_rdy", g_rsp_rdy, 0);
        check("rst_stray", stray, 0);

        // 1: host0 single read, response three cycles later
        tick(); rst_n = 1'b1; hv = 2'b00; g_rsp_vld = 1'b0;
        tick();
        p0 = mk_req(1'b0, 4'd5, 32'h1000_0000, 32'h0);
        hpkt[0] = p0; hv = 2'b01; #1;
        check("t1_req_vld", g_req_vld, 1);
        check("t1_req_pkt", g_req_pkt, p0);
        check("t1_hrdy", hrdy, 2'b01);
        tick(); hv = 2'b00; #1;
        check("t1_pend_no_req", g_req_vld, 0);
        tick();
        tick(); r = mk_rsp(1'b1, 4'd5, 32'hA5A5_0001); g_rsp_vld = 1'b1; g_rsp_pkt = r; #1;
        check("t1_rsp_vld", hrsp_vld, 2'b01);
        check("t1_rsp_pkt", hrsp_pkt[0], r);
        check("t1_rsp_rdy", g_rsp_rdy, 1);
        tick(); g_rsp_vld = 1'b0; #1;
        check("t1_rsp_done", hrsp_vld, 0);
        check("t1_no_stray", stray, 0);

        // 2/4: both hosts always valid, rsp overlaps the next req; grants alternate from ptr=1
        p0 = mk_req(1'b0, 4'd1, 32'h1000_0010, 32'h0);
        p1 = mk_req(1'b1, 4'd2, 32'h2000_0000, 32'h1234_5678);
        hpkt[0] = p0; hpkt[1] = p1;
        last_g = 0;
        for (int k = 0; k < 5; k++) begin
            int exp_g;
            exp_g = (k % 2 == 0) ? 1 : 0;
            tick(); hv = 2'b11;
            r = mk_rsp(1'b1, 4'(k), 32'hC0DE_0000 + 32'(k));
            g_rsp_pkt = r; g_rsp_vld = (k > 0); #1;
            if (k > 0) begin
                check("t2_rsp_route", hrsp_vld, oh(last_g));
                check("t2_rsp_pkt", hrsp_pkt[last_g], r);
            end
            check("t2_req_vld", g_req_vld, 1);
            check("t2_grant", hrdy, oh(exp_g));
            check("t2_req_pkt", g_req_pkt, (exp_g == 1) ? p1 : p0);
            last_g = exp_g;
        end
        tick(); hv = 2'b00; g_rsp_vld = 1'b1; #1;
        check("t2_drain_route", hrsp_vld, oh(last_g));
        check("t2_drain_no_req", g_req_vld, 0);
        tick(); g_rsp_vld = 1'b0;

        // 3: host1 offered, gst stalls 4 cycles while host0 raises vld; lock holds host1
        p1 = mk_req(1'b0, 4'd3, 32'h2000_0004, 32'h0);
        hpkt[1] = p1; hv = 2'b10; g_req_rdy = 1'b0; #1;
        check("t3_c1_pkt", g_req_pkt, p1);
        check("t3_c1_hrdy", hrdy, 0);
        for (int c = 2; c <= 4; c++) begin
            tick(); hv = 2'b11; #1;
            check("t3_lock_pkt", g_req_pkt, p1);
            check("t3_lock_vld", g_req_vld, 1);
        end
        tick(); g_req_rdy = 1'b1; #1;
        check("t3_c5_pkt", g_req_pkt, p1);
        check("t3_c5_hrdy", hrdy, 2'b10);
        tick(); hv = 2'b01; r = mk_rsp(1'b1, 4'd3, 32'h0000_0044); g_rsp_pkt = r; g_rsp_vld = 1'b1; #1;
        check("t3_rsp_h1", hrsp_vld, 2'b10);
        check("t3_next_h0", hrdy, 2'b01);
        check("t3_next_pkt", g_req_pkt, p0);

        // 5: host0 rsp backpressure stalls the response and blocks new requests
        for (int c = 0; c < 3; c++) begin
            tick(); hv = 2'b11; hrsp_rdy = 2'b10; r = mk_rsp(1'b1, 4'd7, 32'h7777_0000); g_rsp_pkt = r; #1;
            check("t5_hold_vld", hrsp_vld, 2'b01);
            check("t5_hold_rdy", g_rsp_rdy, 0);
            check("t5_no_req", g_req_vld, 0);
        end
        tick(); hrsp_rdy = 2'b11; #1;
        check("t5_rel_rdy", g_rsp_rdy, 1);
        check("t5_rel_grant", hrdy, 2'b10);
        tick(); hv = 2'b00; r = mk_rsp(1'b1, 4'd3, 32'h8888_0000); g_rsp_pkt = r; #1;
        check("t5_h1_rsp", hrsp_vld, 2'b10);
        check("t5_idle", g_req_vld, 0);
        tick(); g_rsp_vld = 1'b0;

        // 6: stray response, then reset in the middle of a pending read
        tick(); g_rsp_pkt = mk_rsp(1'b1, 4'd0, 32'hDEAD_BEEF); g_rsp_vld = 1'b1; #1;
        check("t6_stray_rdy", g_rsp_rdy, 1);
        check("t6_stray_hidden", hrsp_vld, 0);
        tick(); g_rsp_vld = 1'b0; #1;
        check("t6_stray_pulse", stray, 1);
        tick(); #1;
        check("t6_stray_once", stray, 0);
        hv = 2'b01; #1;
        check("t6_req_h0", hrdy, 2'b01);
        tick(); hv = 2'b11; #1;
        check("t6_pend_block", g_req_vld, 0);
        rst_n = 1'b0; #1;
        check("t6_rst_req_vld", g_req_vld, 0);
        check("t6_rst_hrdy", hrdy, 0);
        check("t6_rst_rsp_rdy", g_rsp_rdy, 0);
        tick(); rst_n = 1'b1; hv = 2'b00; g_rsp_vld = 1'b1; #1;
        check("t6_late_hidden", hrsp_vld, 0);
        check("t6_late_rdy", g_rsp_rdy, 1);
        tick(); g_rsp_vld = 1'b0; hv = 2'b11; #1;
        check("t6_late_stray", stray, 1);
        check("t6_ptr_reset", hrdy, 2'b01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
